// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch with one-word immediate pairing, stall and jump redirect.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_stage (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_data,
   input  logic        stall,
   input  logic        jump_occured,
   input  logic [15:0] jump_target,
   output logic [15:0] instruction,
   output logic [15:0] immediate,
   output logic [15:0] pc_out,
   output logic        instr_valid,
   output logic        flush,
   output logic [15:0] fetch_count,
   output logic [15:0] flush_count
);

   localparam logic [1:0] IMM_TAG = 2'b11;

   typedef enum logic [0:0] {
      S_FETCH = 1'b0,
      S_IMM   = 1'b1
   } state_t;

   state_t      state_q;
   logic [15:0] pc_q;
   logic [15:0] pending_q;
   logic [15:0] pending_pc_q;
   logic [15:0] instruction_q;
   logic [15:0] immediate_q;
   logic [15:0] pc_out_q;
   logic        instr_valid_q;
   logic        flush_q;
   logic        imm_word_d;

   assign imm_word_d = (imem_data[15:14] == IMM_TAG);
   assign imem_addr  = pc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_FETCH;
         pc_q          <= 16'h0000;
         pending_q     <= 16'h0000;
         pending_pc_q  <= 16'h0000;
         instruction_q <= 16'h0000;
         immediate_q   <= 16'h0000;
         pc_out_q      <= 16'h0000;
         instr_valid_q <= 1'b0;
         flush_q       <= 1'b0;
      end else if (jump_occured) begin
         // Redirect wins over stall; any half-fetched imm pair is dropped.
         state_q       <= S_FETCH;
         pc_q          <= jump_target;
         pending_q     <= 16'h0000;
         pending_pc_q  <= 16'h0000;
         instr_valid_q <= 1'b0;
         flush_q       <= 1'b1;
      end else if (stall) begin
         flush_q <= 1'b0;
      end else begin
         flush_q <= 1'b0;
         pc_q    <= pc_q + 16'd1;
         if (state_q == S_IMM) begin
            instruction_q <= pending_q;
            immediate_q   <= imem_data;
            pc_out_q      <= pending_pc_q;
            instr_valid_q <= 1'b1;
            state_q       <= S_FETCH;
         end else if (imm_word_d) begin
            pending_q     <= imem_data;
            pending_pc_q  <= pc_q;
            instr_valid_q <= 1'b0;
            state_q       <= S_IMM;
         end else begin
            instruction_q <= imem_data;
            immediate_q   <= 16'h0000;
            pc_out_q      <= pc_q;
            instr_valid_q <= 1'b1;
         end
      end
   end

   assign instruction = instruction_q;
   assign immediate   = immediate_q;
   assign pc_out      = pc_out_q;
   assign instr_valid = instr_valid_q;
   assign flush       = flush_q;

`ifdef FETCH_STATS_EN
   logic [15:0] fetch_count_q;
   logic [15:0] flush_count_q;
   logic        issue_d;

   // An issue is any normal cycle that loads a complete instruction.
   assign issue_d = !jump_occured && !stall && ((state_q == S_IMM) || !imm_word_d);

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_count_q <= 16'h0000;
         flush_count_q <= 16'h0000;
      end else begin
         if (issue_d && (fetch_count_q != 16'hFFFF))
            fetch_count_q <= fetch_count_q + 16'd1;
         if (jump_occured && (flush_count_q != 16'hFFFF))
            flush_count_q <= flush_count_q + 16'd1;
      end
   end

   assign fetch_count = fetch_count_q;
   assign flush_count = flush_count_q;
`else
   assign fetch_count = 16'h0000;
   assign flush_count = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Directed self-checking bench for fetch_stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;

   logic        clk;
   logic        rst;
   logic [15:0] imem_addr;
   logic [15:0] imem_data;
   logic        stall;
   logic        jump_occured;
   logic [15:0] jump_target;
   logic [15:0] instruction;
   logic [15:0] immediate;
   logic [15:0] pc_out;
   logic        instr_valid;
   logic        flush;
   logic [15:0] fetch_count;
   logic [15:0] flush_count;

   logic [15:0] mem [0:65535];
   int          n_pass;
   int          n_total;
   int          exp_fetch;
   int          exp_flush;

   fetch_stage dut (
      .clk          (clk),
      .rst          (rst),
      .imem_addr    (imem_addr),
      .imem_data    (imem_data),
      .stall        (stall),
      .jump_occured (jump_occured),
      .jump_target  (jump_target),
      .instruction  (instruction),
      .immediate    (immediate),
      .pc_out       (pc_out),
      .instr_valid  (instr_valid),
      .flush        (flush),
      .fetch_count  (fetch_count),
      .flush_count  (flush_count)
   );

   assign imem_data = mem[imem_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "simulation timeout");
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [15:0] ins, input logic [15:0] imm,
                          input logic [15:0] pc, input logic v, input logic fl, input logic [15:0] addr);
      chk({tag, ".instruction"}, instruction, ins);
      chk({tag, ".immediate"},   immediate,   imm);
      chk({tag, ".pc_out"},      pc_out,      pc);
      chk({tag, ".valid"},       {15'd0, instr_valid}, {15'd0, v});
      chk({tag, ".flush"},       {15'd0, flush},       {15'd0, fl});
      chk({tag, ".imem_addr"},   imem_addr,   addr);
   endtask

   task automatic chk_counts(input string tag);
`ifdef FETCH_STATS_EN
      chk({tag, ".fetch_count"}, fetch_count, exp_fetch[15:0]);
      chk({tag, ".flush_count"}, flush_count, exp_flush[15:0]);
`else
      chk({tag, ".fetch_count"}, fetch_count, 16'h0000);
      chk({tag, ".flush_count"}, flush_count, 16'h0000);
`endif
   endtask

   initial begin
      n_pass = 0; n_total = 0; exp_fetch = 0; exp_flush = 0;
      for (int a = 0; a < 65536; a++) mem[a] = {2'b00, a[13:0]};
      mem[16'h0000] = 16'h1234;
      mem[16'h0001] = 16'h2000;
      mem[16'h0004] = 16'hC005;
      mem[16'h0005] = 16'h00AA;
      mem[16'h0007] = 16'hC111;
      mem[16'h0040] = 16'h1040;
      mem[16'hFFFF] = 16'hC001;
      mem[16'h0200] = 16'hC222;

      rst = 1'b1; stall = 1'b0; jump_occured = 1'b0; jump_target = 16'h0000;
      step();
      chk_out("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
      chk_counts("reset");

      rst = 1'b0;
      step(); exp_fetch++;
      chk_out("first", 16'h1234, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001);
      step(); exp_fetch++;
      chk_out("second", 16'h2000, 16'h0000, 16'h0001, 1'b1, 1'b0, 16'h0002);
      step(); exp_fetch++;
      step(); exp_fetch++;
      chk_out("fourth", 16'h0003, 16'h0000, 16'h0003, 1'b1, 1'b0, 16'h0004);

      // Immediate pair at 4/5: valid drops for one cycle.
      step();
      chk({"imm_first.valid"}, {15'd0, instr_valid}, 16'h0000);
      chk({"imm_first.imem_addr"}, imem_addr, 16'h0005);
      step(); exp_fetch++;
      chk_out("imm_pair", 16'hC005, 16'h00AA, 16'h0004, 1'b1, 1'b0, 16'h0006);

      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_out("stall", 16'hC005, 16'h00AA, 16'h0004, 1'b1, 1'b0, 16'h0006);
      end
      stall = 1'b0;
      step(); exp_fetch++;
      chk_out("resume", 16'h0006, 16'h0000, 16'h0006, 1'b1, 1'b0, 16'h0007);

      // Enter IMM with C111, then jump while stalled.
      step();
      chk({"pre_jump.valid"}, {15'd0, instr_valid}, 16'h0000);
      stall = 1'b1; jump_occured = 1'b1; jump_target = 16'h0040;
      step(); exp_flush++;
      chk({"jump1.flush"}, {15'd0, flush}, 16'h0001);
      chk({"jump1.valid"}, {15'd0, instr_valid}, 16'h0000);
      chk({"jump1.imem_addr"}, imem_addr, 16'h0040);
      stall = 1'b0; jump_occured = 1'b0;
      step(); exp_fetch++;
      chk_out("after_jump", 16'h1040, 16'h0000, 16'h0040, 1'b1, 1'b0, 16'h0041);
      chk_counts("mid");

      jump_occured = 1'b1; jump_target = 16'hFFFF;
      step(); exp_flush++;
      chk({"jump2.flush"}, {15'd0, flush}, 16'h0001);
      chk({"jump2.imem_addr"}, imem_addr, 16'hFFFF);
      chk_counts("two_jumps");
      jump_occured = 1'b0;
      mem[16'h0000] = 16'h0007;

      // Immediate pair straddling the address wrap.
      step();
      chk({"wrap_first.valid"}, {15'd0, instr_valid}, 16'h0000);
      chk({"wrap_first.imem_addr"}, imem_addr, 16'h0000);
      step(); exp_fetch++;
      chk_out("wrap_pair", 16'hC001, 16'h0007, 16'hFFFF, 1'b1, 1'b0, 16'h0001);

      jump_occured = 1'b1; jump_target = 16'h0100;
      step();
      jump_target = 16'h0200;
      step();
      chk({"jump_back2back.flush"}, {15'd0, flush}, 16'h0001);
      chk({"jump_back2back.imem_addr"}, imem_addr, 16'h0200);
      jump_occured = 1'b0;

      // Reset overrides jump and stall while an imm pair is half-fetched.
      step();
      chk({"pre_rst.valid"}, {15'd0, instr_valid}, 16'h0000);
      rst = 1'b1; jump_occured = 1'b1; jump_target = 16'h0300; stall = 1'b1;
      step();
      exp_fetch = 0; exp_flush = 0;
      chk_out("rst_override", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
      chk_counts("rst_override");

      rst = 1'b0; jump_occured = 1'b0; stall = 1'b0;
      step(); exp_fetch++;
      chk_out("post_rst", 16'h0007, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001);
      chk_counts("post_rst");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on posedge clk.
REQ-002 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-003 SHALL have port imem_addr, output, 16, instruction-memory word address, combinationally equal to internal PC.
REQ-004 SHALL have port imem_data, input, 16, instruction-memory word at imem_addr, valid in the same cycle.
REQ-005 SHALL have port stall, input, 1, hold request from the hazard unit.
REQ-006 SHALL have port jump_occured, input, 1, taken-jump indication from the ALU stage.
REQ-007 SHALL have port jump_target, input, 16, redirect address, sampled when jump_occured=1.
REQ-008 SHALL have port instruction, output, 16, fetched instruction word to decode.
REQ-009 SHALL have port immediate, output, 16, immediate word paired with instruction, 0 when none.
REQ-010 SHALL have port pc_out, output, 16, address of the first word of the presented instruction.
REQ-011 SHALL have port instr_valid, output, 1, instruction/immediate/pc_out form a valid issue.
REQ-012 SHALL have port flush, output, 1, one-cycle pulse telling downstream stages to squash.
REQ-013 SHALL have ports fetch_count and flush_count, output, 16 each, statistics (see Configuration).

Function
REQ-014 SHALL treat a word as immediate-carrying when imem_data[15:14]=2'b11.
REQ-015 SHALL implement states FETCH and IMM; per-cycle priority SHALL be rst > jump_occured > stall > normal.
REQ-016 FETCH, normal, non-imm word: instruction<=imem_data, immediate<=0, pc_out<=PC, instr_valid<=1, PC<=PC+1, stay FETCH.
REQ-017 FETCH, normal, imm word: pending<=imem_data, pending_pc<=PC, instr_valid<=0, PC<=PC+1, go IMM.
REQ-018 IMM, normal: instruction<=pending, immediate<=imem_data, pc_out<=pending_pc, instr_valid<=1, PC<=PC+1, go FETCH.
REQ-019 Latency SHALL be one cycle from word address to instr_valid for non-imm, two cycles for imm instructions.
REQ-020 stall=1 (no jump): PC, state, pending, and all outputs SHALL hold; flush<=0.
REQ-021 jump_occured=1: PC<=jump_target, state<=FETCH, pending discarded, instr_valid<=0, flush<=1, regardless of stall or state.
REQ-022 flush SHALL be 1 only in the cycle after a jump; consecutive jumps SHALL keep flush=1 and use the latest target.
REQ-023 PC increment SHALL wrap 16'hFFFF -> 16'h0000 without error; an imm pair straddling the wrap SHALL be fetched normally.

Reset
REQ-024 rst=1 at posedge SHALL set PC=0, state=FETCH, pending=0, instruction=0, immediate=0, pc_out=0, instr_valid=0, flush=0, fetch_count=0, flush_count=0.
REQ-025 rst SHALL override jump_occured and stall in the same cycle; a partially fetched imm pair SHALL be discarded.
REQ-026 First fetch SHALL occur from address 0 in the first cycle with rst=0.

Configuration
REQ-027 Macro FETCH_STATS_EN defined: fetch_count SHALL increment on each cycle instr_valid rises or is newly reloaded with a valid issue; flush_count SHALL increment on each flush pulse; both SHALL saturate at 16'hFFFF.
REQ-028 Macro FETCH_STATS_EN undefined: fetch_count and flush_count SHALL be constant 0 and no counter registers synthesized.

Verification
REQ-029 Mem[0]=16'h1234, Mem[1]=16'h2000, no stall -> cycle1 instruction=1234 pc_out=0 valid=1; cycle2 instruction=2000 pc_out=1.
REQ-030 Mem[4]=16'hC005, Mem[5]=16'h00AA, PC=4 -> cycle1 valid=0; cycle2 instruction=C005 immediate=00AA pc_out=4 valid=1.
REQ-031 stall=1 for 3 cycles mid-stream -> outputs and imem_addr constant for 3 cycles, resume at next address with no skipped word.
REQ-032 jump_occured=1, jump_target=16'h0040, while in IMM and stall=1 -> next cycle flush=1 valid=0 imem_addr=0040; following cycle fetches Mem[0x40].
REQ-033 PC=16'hFFFF, Mem[FFFF]=16'hC001, Mem[0]=16'h0007 -> instruction=C001 immediate=0007 pc_out=FFFF, then imem_addr=0001.
REQ-034 FETCH_STATS_EN defined: 5 issues plus 2 jumps, then rst=1 -> counts 5 and 2, then both 0; undefined -> both 0 throughout.
